// File: rtl/img_loader_pkg.sv
// Shared image geometry, bus widths and FSM state encoding for the image
// loader and the downstream median filter.
package img_loader_pkg;

  localparam int unsigned IMG_W  = 256;
  localparam int unsigned IMG_H  = 256;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COL_W  = 8;
  localparam int unsigned ROW_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage : img_loader_pkg

// File: rtl/img_loader.sv
// Streams one raster-order frame into the image RAM at {row,col}, then hands
// control to the median filter and waits for its completion level.
module img_loader #(
  parameter int unsigned IMG_W = img_loader_pkg::IMG_W,
  parameter int unsigned IMG_H = img_loader_pkg::IMG_H
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               in_valid,
  input  logic [img_loader_pkg::PIX_W-1:0]   in_data,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic                               RAM_IMG_WE,
  output logic                               RAM_IMG_OE,
  output logic [img_loader_pkg::ADDR_W-1:0]  RAM_IMG_A,
  output logic [img_loader_pkg::PIX_W-1:0]   RAM_IMG_D,
  output logic                               filt_enable,
  input  logic                               filt_done,
  output logic                               busy,
  output logic                               frame_err,
  output logic                               done
);

  import img_loader_pkg::*;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic                fen_q, fen_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                hs_c;
  logic                last_pix_c;

  assign hs_c       = in_valid && ready_q;
  assign last_pix_c = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      fen_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fen_q   <= fen_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state, pixel counter and registered RAM write port.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (hs_c) begin
          we_d   = 1'b1;
          addr_d = {row_q, col_q};
          data_d = in_data;
          if (last_pix_c) begin
            col_d   = '0;
            row_d   = '0;
            state_d = RUN;
            if (!in_last) err_d = 1'b1;
          end else begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            if (in_last) begin
              err_d   = 1'b1;
              state_d = FIN;
            end
          end
        end
      end
      RUN: begin
        if (filt_done) state_d = FIN;
      end
      FIN: begin
        state_d = FIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Filter enable starts the cycle after the final write and drops with RUN.
    ready_d = (state_d == LOAD);
    busy_d  = (state_d == LOAD) || (state_d == RUN);
    done_d  = (state_d == FIN);
    fen_d   = (state_q == RUN) && (state_d == RUN);
  end

  assign in_ready    = ready_q;
  assign RAM_IMG_WE  = we_q;
  assign RAM_IMG_OE  = 1'b0;
  assign RAM_IMG_A   = addr_q;
  assign RAM_IMG_D   = data_q;
  assign filt_enable = fen_q;
  assign busy        = busy_q;
  assign frame_err   = err_q;
  assign done        = done_q;

endmodule : img_loader

// File: tb/tb_img_loader.sv
// Directed bench for img_loader on a 16x8 frame: table-driven frame scenarios
// plus hand-written reset and stray-event sequences.
module tb_img_loader;

  localparam int unsigned W    = 16;
  localparam int unsigned H    = 8;
  localparam int          NPIX = W * H;
  localparam int          LOGN = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        filt_done = 1'b0;
  logic        in_ready;
  logic        ram_we;
  logic        ram_oe;
  logic [15:0] ram_a;
  logic [7:0]  ram_d;
  logic        filt_enable;
  logic        busy;
  logic        frame_err;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  img_loader #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .RAM_IMG_WE (ram_we),
    .RAM_IMG_OE (ram_oe),
    .RAM_IMG_A  (ram_a),
    .RAM_IMG_D  (ram_d),
    .filt_enable(filt_enable),
    .filt_done  (filt_done),
    .busy       (busy),
    .frame_err  (frame_err),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Write log and filter-enable history, sampled mid-cycle.
  int          wr_cnt = 0;
  logic [15:0] wr_addr [LOGN];
  logic [7:0]  wr_data [LOGN];
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          fen_rise_cyc = 0;
  int          fen_cnt = 0;
  int          oe_cnt = 0;
  logic        fen_prev = 1'b0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    fen_prev <= filt_enable;
    if (ram_oe) oe_cnt <= oe_cnt + 1;
    if (filt_enable) fen_cnt <= fen_cnt + 1;
    if (filt_enable && !fen_prev) fen_rise_cyc <= cyc;
    if (ram_we) begin
      if (wr_cnt < LOGN) begin
        wr_addr[wr_cnt] <= ram_a;
        wr_data[wr_cnt] <= ram_d;
      end
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
  end

  function automatic logic [15:0] exp_addr(input int i);
    logic [7:0] r;
    logic [7:0] c;
    r = 8'(i / W);
    c = 8'(i % W);
    return {r, c};
  endfunction

  function automatic logic [7:0] pat(input int i);
    logic [15:0] a;
    a = exp_addr(i);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    filt_done = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_done();
    filt_done = 1'b1;
    tick(1);
    filt_done = 1'b0;
  endtask

  // Send pixels base..base+n-1; gap inserts an idle cycle between offers.
  task automatic stream(input int base, input int n, input int last_idx, input bit gap);
    int sent = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit hs;
    while (sent < n && guard < 4 * n + 16) begin
      if (gap && ph) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = pat(base + sent);
        in_last  = ((base + sent) == last_idx);
      end
      ph = !ph;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) sent++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stream_accepted", 32'(sent), 32'(n));
  endtask

  task automatic check_log(input string name, input int base, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (base + i >= LOGN) bad++;
      else if (wr_addr[base + i] !== exp_addr(i) || wr_data[base + i] !== pat(i)) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int n;
    int last_idx;
    bit gap;
    int exp_wr;
    bit exp_err;
    bit exp_run;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    int fb;

    vecs[0] = '{n: NPIX, last_idx: NPIX - 1, gap: 1'b0, exp_wr: NPIX, exp_err: 1'b0, exp_run: 1'b1};
    vecs[1] = '{n: NPIX, last_idx: NPIX - 1, gap: 1'b1, exp_wr: NPIX, exp_err: 1'b0, exp_run: 1'b1};
    vecs[2] = '{n: 101,  last_idx: 100,      gap: 1'b0, exp_wr: 101,  exp_err: 1'b1, exp_run: 1'b0};
    vecs[3] = '{n: NPIX, last_idx: -1,       gap: 1'b0, exp_wr: NPIX, exp_err: 1'b1, exp_run: 1'b1};
    vecs[4] = '{n: 1,    last_idx: 0,        gap: 1'b0, exp_wr: 1,    exp_err: 1'b1, exp_run: 1'b0};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      check("reset_outputs", {in_ready, ram_we, ram_a, ram_d, filt_enable, busy, frame_err, done}, 32'd0);
      pulse_start();
      check("ready_in_load", {in_ready, busy}, 32'h3);
      wb = wr_cnt;
      fb = fen_cnt;
      stream(0, vecs[v].n, vecs[v].last_idx, vecs[v].gap);
      tick(2);
      check("write_count", 32'(wr_cnt - wb), 32'(vecs[v].exp_wr));
      check_log("write_addr_data", wb, vecs[v].exp_wr);
      check("frame_err", frame_err, vecs[v].exp_err);
      check("filt_enable_after_load", filt_enable, vecs[v].exp_run);
      check("done_after_load", done, !vecs[v].exp_run);
      check("busy_after_load", busy, vecs[v].exp_run);
      check("addr_hold", ram_a, exp_addr(vecs[v].exp_wr - 1));
      check("data_hold", ram_d, pat(vecs[v].exp_wr - 1));
      check("ready_after_load", in_ready, 1'b0);
      if (vecs[v].exp_run) begin
        check("fen_rise_latency", 32'(fen_rise_cyc - last_wr_cyc), 32'd1);
        pulse_done();
        tick(1);
        check("done_after_filt", {done, filt_enable, busy}, 32'h4);
      end else begin
        pulse_done();
        tick(1);
        check("fen_never_set", 32'(fen_cnt - fb), 32'd0);
        check("fin_holds", {done, busy}, 32'h2);
      end
    end

    // Asynchronous reset part-way through a frame, then a clean reload.
    do_reset();
    pulse_start();
    stream(0, 50, -1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {in_ready, ram_we, ram_oe, ram_a, ram_d, filt_enable, busy, frame_err, done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    wb = wr_cnt;
    stream(0, 3, -1, 1'b0);
    tick(2);
    check("reload_count", 32'(wr_cnt - wb), 32'd3);
    check("reload_first_addr", wr_addr[wb], 32'd0);
    check("reload_busy", busy, 1'b1);

    // Stray start and filt_done while loading must not disturb the frame.
    do_reset();
    pulse_start();
    wb = wr_cnt;
    stream(0, 20, -1, 1'b0);
    start = 1'b1;
    filt_done = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    filt_done = 1'b0;
    check("stray_still_loading", {in_ready, busy, done}, 32'h6);
    stream(20, NPIX - 20, NPIX - 1, 1'b0);
    tick(2);
    check("stray_write_count", 32'(wr_cnt - wb), 32'(NPIX));
    check_log("stray_addr_data", wb, NPIX);
    check("stray_run", {filt_enable, frame_err}, 32'h2);

    check("oe_never_set", 32'(oe_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_img_loader
